// File: rtl/riscv_ctrl_defs.sv
// Shared control definitions for the multicycle RV32I core: opcodes, FSM state
// encoding, instruction classes and datapath select codes.
package riscv_ctrl_defs;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Bit positions of the one-hot instruction class vector
    localparam int CLS_LW      = 0;
    localparam int CLS_SW      = 1;
    localparam int CLS_R       = 2;
    localparam int CLS_I       = 3;
    localparam int CLS_BEQ     = 4;
    localparam int CLS_JAL     = 5;
    localparam int NUM_CLASSES = 6;

    localparam logic [6:0] CLASS_OP [NUM_CLASSES] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/op_classifier.sv
// Combinational opcode decoder: one-hot instruction class, immediate format
// select and legality flag.
module op_classifier
    import riscv_ctrl_defs::*;
#(
    parameter int ENABLE_JAL = 1
) (
    input  logic [6:0]             op,
    output logic [NUM_CLASSES-1:0] op_class,
    output logic [1:0]             immsrc,
    output logic                   legal
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
            if (gi == CLS_JAL && ENABLE_JAL == 0) begin : g_jal_off
                assign op_class[gi] = 1'b0;
            end else begin : g_match
                assign op_class[gi] = (op == CLASS_OP[gi]);
            end
        end
    endgenerate

    assign legal = |op_class;

    always_comb begin
        immsrc = IMM_I;
        if (op_class[CLS_SW])  immsrc = IMM_S;
        if (op_class[CLS_BEQ]) immsrc = IMM_B;
        if (op_class[CLS_JAL]) immsrc = IMM_J;
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core with memory wait states and a
// sticky illegal-opcode flag.
module multicycle_main_fsm
    import riscv_ctrl_defs::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_JAL    = 1,
    parameter int TRAP_ILLEGAL  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcupdate,
    output logic       branch,
    output logic       regwrite,
    output logic       memwrite,
    output logic       irwrite,
    output logic       adrsrc,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] immsrc,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t                 state_reg, state_next;
    logic                   illegal_reg, illegal_next;
    logic [NUM_CLASSES-1:0] op_class;
    logic                   op_legal;
    logic                   ready;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    op_classifier #(
        .ENABLE_JAL(ENABLE_JAL)
    ) u_op_classifier (
        .op      (op),
        .op_class(op_class),
        .immsrc  (immsrc),
        .legal   (op_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        mem_req      = 1'b0;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        regwrite     = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        adrsrc       = 1'b0;
        resultsrc    = RES_ALUOUT;
        alusrca      = SRCA_PC;
        alusrcb      = SRCB_RS2;
        aluop        = ALUOP_ADD;

        case (state_reg)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                irwrite   = ready;
                pcupdate  = ready;
                if (ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                // ALU precomputes the branch target from OldPC + imm
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                if (op_class[CLS_LW] || op_class[CLS_SW]) state_next = ST_MEMADR;
                else if (op_class[CLS_R])                 state_next = ST_EXECR;
                else if (op_class[CLS_I])                 state_next = ST_EXECI;
                else if (op_class[CLS_BEQ])               state_next = ST_BEQ;
                else if (op_class[CLS_JAL])               state_next = ST_JAL;
                if (!op_legal) begin
                    illegal_next = 1'b1;
                    state_next   = (TRAP_ILLEGAL != 0) ? ST_HALT : ST_FETCH;
                end
            end
            ST_MEMADR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                // Anything that is not a store is treated as a load here
                state_next = op_class[CLS_SW] ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                if (ready) state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite   = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWRITE: begin
                mem_req  = 1'b1;
                adrsrc   = 1'b1;
                memwrite = ready;
                if (ready) state_next = ST_FETCH;
            end
            ST_EXECR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_RS2;
                aluop      = ALUOP_FUNCT;
                state_next = ST_ALUWB;
            end
            ST_EXECI: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                state_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                regwrite   = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BEQ: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_RS2;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                pcupdate   = 1'b1;
                state_next = ST_ALUWB;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase

        // Strobes must never fire while reset is held, whatever the state
        if (reset) begin
            mem_req  = 1'b0;
            pcupdate = 1'b0;
            branch   = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
        end
    end

    assign illegal   = illegal_reg;
    assign state_dbg = state_reg;

endmodule
